regfile_multiport: RTL and testbench

REGFILE_MULTIPORT -- requirements
Module: regfile_multiport

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_multiport_if.sv | 36 +++
 rtl/regfile_clear_ctrl.sv | 62 ++++++
 rtl/regfile_multiport.sv | 108 ++++++++++
 tb/tb_regfile_multiport.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the multiport register file slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_N_READ     = 2;

  // Clear-sweep controller states.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/regfile_multiport_if.sv
// Bus bundle between a register-file user (master) and the register file (slave).
// Latency: n/a (wiring only); read data lands one cycle after the request.
// Backpressure: none on the bus itself; o_busy tells the master that requests are ignored.
// Ports: read requests/indices, write request/index/data, clear pulse, debug index,
//        read data/valid, debug data, busy flag.
interface regfile_multiport_if
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int N_READ     = DEF_N_READ
);

  logic [N_READ-1:0]            i_rd_en;
  logic [N_READ*ADDR_WIDTH-1:0] i_rd_addr;
  logic                         i_wr_en;
  logic [ADDR_WIDTH-1:0]        i_wr_addr;
  logic [DATA_WIDTH-1:0]        i_wr_data;
  logic                         i_clear;
  logic [ADDR_WIDTH-1:0]        i_dbg_addr;
  logic [N_READ*DATA_WIDTH-1:0] o_rd_data;
  logic [N_READ-1:0]            o_rd_valid;
  logic [DATA_WIDTH-1:0]        o_dbg_data;
  logic                         o_busy;

  modport master (
    output i_rd_en, i_rd_addr, i_wr_en, i_wr_addr, i_wr_data, i_clear, i_dbg_addr,
    input  o_rd_data, o_rd_valid, o_dbg_data, o_busy
  );

  modport slave (
    input  i_rd_en, i_rd_addr, i_wr_en, i_wr_addr, i_wr_data, i_clear, i_dbg_addr,
    output o_rd_data, o_rd_valid, o_dbg_data, o_busy
  );

endinterface

// File: rtl/regfile_clear_ctrl.sv
// Clear-sweep FSM: walks an index 0..depth-1 zeroing one register per cycle.
// Latency: sweep lasts exactly 2**ADDR_WIDTH cycles from reset release or the i_clear edge.
// Backpressure: o_busy stays high for the whole sweep; a new i_clear restarts it at index 0.
// Ports: i_clk, i_reset, i_clear in; o_busy, o_clr_idx, o_clr_we out (all registered).
module regfile_clear_ctrl
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_clear,
  output logic                  o_busy,
  output logic [ADDR_WIDTH-1:0] o_clr_idx,
  output logic                  o_clr_we
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

  clr_state_t            state;
  logic [ADDR_WIDTH-1:0] cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      // Reset parks the FSM at the start of a sweep so storage is zeroed after release.
      state  <= ST_CLEAR;
      cnt    <= '0;
      o_busy <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_clear) begin
            state  <= ST_CLEAR;
            cnt    <= '0;
            o_busy <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (i_clear) begin
            cnt <= '0;
          end else if (cnt == LAST_IDX) begin
            // Last index is zeroed on this edge; counter never wraps.
            state  <= ST_IDLE;
            cnt    <= '0;
            o_busy <= 1'b0;
          end else begin
            cnt <= cnt + ADDR_WIDTH'(1);
          end
        end
        default: begin
          state  <= ST_CLEAR;
          cnt    <= '0;
          o_busy <= 1'b1;
        end
      endcase
    end
  end

  assign o_clr_idx = cnt;
  assign o_clr_we  = o_busy;

endmodule

// File: rtl/regfile_multiport.sv
// Multiport register file: N_READ read ports plus a debug port, one write port, r0 hard-wired to 0.
// Latency: one cycle for reads and debug, write-first bypass on same-index read/write.
// Backpressure: while o_busy (clear sweep) writes are dropped and all read outputs return 0.
// Ports: i_clk, i_reset (async, active-high) and the slave side of regfile_multiport_if.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int N_READ     = DEF_N_READ
) (
  input  logic                i_clk,
  input  logic                i_reset,
  regfile_multiport_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic                  busy;
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_idx;
  logic                  wr_commit;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q  [N_READ];
  logic                  rd_valid_q [N_READ];
  logic [DATA_WIDTH-1:0] dbg_fwd;

  regfile_clear_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear_ctrl (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (bus.i_clear),
    .o_busy    (busy),
    .o_clr_idx (clr_idx),
    .o_clr_we  (clr_we)
  );

  assign bus.o_busy = busy;

  // A clear request in the same cycle wins over the write, so it also kills the bypass.
  assign wr_commit = bus.i_wr_en && !busy && !bus.i_clear && (bus.i_wr_addr != '0);

  // Storage has no reset; the sweep is the only thing that zeroes it.
  always_ff @(posedge i_clk) begin
    if (clr_we) begin
      mem[clr_idx] <= '0;
    end else if (wr_commit) begin
      mem[bus.i_wr_addr] <= bus.i_wr_data;
    end
  end

  for (genvar k = 0; k < N_READ; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] fwd;

    assign addr = bus.i_rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      fwd = mem[addr];
      if (addr == '0) begin
        fwd = '0;
      end else if (wr_commit && (addr == bus.i_wr_addr)) begin
        fwd = bus.i_wr_data;
      end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        rd_data_q[k]  <= '0;
        rd_valid_q[k] <= 1'b0;
      end else if (busy) begin
        rd_data_q[k]  <= '0;
        rd_valid_q[k] <= 1'b0;
      end else if (bus.i_rd_en[k]) begin
        rd_data_q[k]  <= fwd;
        rd_valid_q[k] <= 1'b1;
      end else begin
        // Data holds its last value when the port is not requested.
        rd_valid_q[k] <= 1'b0;
      end
    end

    assign bus.o_rd_data[k*DATA_WIDTH +: DATA_WIDTH] = rd_data_q[k];
    assign bus.o_rd_valid[k]                         = rd_valid_q[k];
  end

  always_comb begin
    dbg_fwd = mem[bus.i_dbg_addr];
    if (bus.i_dbg_addr == '0) begin
      dbg_fwd = '0;
    end else if (wr_commit && (bus.i_dbg_addr == bus.i_wr_addr)) begin
      dbg_fwd = bus.i_wr_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      bus.o_dbg_data <= '0;
    end else if (busy) begin
      bus.o_dbg_data <= '0;
    end else begin
      bus.o_dbg_data <= dbg_fwd;
    end
  end

endmodule

// File: tb/tb_regfile_multiport.sv
module tb_regfile_multiport;
  import regfile_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  localparam int S_D0 = 0, S_D1 = 1, S_V0 = 2, S_V1 = 3, S_DBG = 4, S_BUSY = 5;

  logic i_clk = 1'b0;
  logic i_reset;

  always #5 i_clk = ~i_clk;

  regfile_multiport_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_READ(NR)) bus ();

  regfile_multiport #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_READ(NR)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  function automatic logic [31:0] observe(int sel);
    case (sel)
      S_D0:    return bus.o_rd_data[0 +: DW];
      S_D1:    return bus.o_rd_data[DW +: DW];
      S_V0:    return {31'b0, bus.o_rd_valid[0]};
      S_V1:    return {31'b0, bus.o_rd_valid[1]};
      S_DBG:   return bus.o_dbg_data;
      default: return {31'b0, bus.o_busy};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
  endtask

  task automatic push(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.sel), e.val);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
    drain();
  endtask

  task automatic set_rd(input logic [1:0] en, input int a0, input int a1);
    bus.i_rd_en   = en;
    bus.i_rd_addr = {AW'(a1), AW'(a0)};
  endtask

  task automatic set_wr(input logic en, input int a, input logic [31:0] d);
    bus.i_wr_en   = en;
    bus.i_wr_addr = AW'(a);
    bus.i_wr_data = d;
  endtask

  // Steps while busy, bounded; returns the number of cycles busy was seen high.
  task automatic wait_idle(output int n);
    n = 0;
    while (bus.o_busy === 1'b1 && n < 200) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    i_reset = 1'b0;
    set_rd(2'b00, 0, 0);
    set_wr(1'b0, 0, 32'h0);
    bus.i_clear    = 1'b0;
    bus.i_dbg_addr = '0;

    // Reset state, visible without a clock edge.
    #2 i_reset = 1'b1;
    #1;
    push("rst_busy", S_BUSY, 32'd1);
    push("rst_v0", S_V0, 32'd0);
    push("rst_v1", S_V1, 32'd0);
    push("rst_d0", S_D0, 32'd0);
    push("rst_d1", S_D1, 32'd0);
    push("rst_dbg", S_DBG, 32'd0);
    drain();

    // Release reset; sweep must last exactly 32 cycles while reads are suppressed.
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    set_rd(2'b11, 5, 5);
    bus.i_dbg_addr = 5'd5;
    wait_idle(n);
    check("rst_sweep_len", n, 32);
    push("sweep_v0", S_V0, 32'd0);
    push("sweep_v1", S_V1, 32'd0);
    push("sweep_d0", S_D0, 32'd0);
    push("sweep_dbg", S_DBG, 32'd0);
    drain();

    set_rd(2'b01, 5, 0);
    push("post_sweep_d0", S_D0, 32'd0);
    push("post_sweep_v0", S_V0, 32'd1);
    push("post_sweep_v1", S_V1, 32'd0);
    step();

    // Write then read back on port 0 and debug.
    set_rd(2'b00, 0, 0);
    set_wr(1'b1, 5, 32'hDEADBEEF);
    push("wr5_v0_low", S_V0, 32'd0);
    step();
    set_wr(1'b0, 0, 32'h0);
    set_rd(2'b01, 5, 0);
    push("rd5_d0", S_D0, 32'hDEADBEEF);
    push("rd5_v0", S_V0, 32'd1);
    push("rd5_dbg", S_DBG, 32'hDEADBEEF);
    step();
    set_rd(2'b00, 5, 0);
    push("hold_v0", S_V0, 32'd0);
    push("hold_d0", S_D0, 32'hDEADBEEF);
    step();

    // Same-cycle write/read bypass on both ports and debug.
    set_wr(1'b1, 7, 32'h12345678);
    set_rd(2'b11, 7, 7);
    bus.i_dbg_addr = 5'd7;
    push("byp_d0", S_D0, 32'h12345678);
    push("byp_d1", S_D1, 32'h12345678);
    push("byp_v0", S_V0, 32'd1);
    push("byp_v1", S_V1, 32'd1);
    push("byp_dbg", S_DBG, 32'h12345678);
    step();

    // r0 is hard zero, bypass included.
    set_wr(1'b1, 0, 32'hFFFFFFFF);
    set_rd(2'b01, 0, 0);
    bus.i_dbg_addr = 5'd0;
    push("r0_byp_d0", S_D0, 32'd0);
    push("r0_byp_dbg", S_DBG, 32'd0);
    step();
    set_wr(1'b0, 0, 32'h0);
    push("r0_rd_d0", S_D0, 32'd0);
    push("r0_rd_v0", S_V0, 32'd1);
    step();

    // Clear and write in the same idle cycle: write dropped, no bypass.
    set_rd(2'b00, 0, 0);
    set_wr(1'b1, 9, 32'h55);
    step();
    set_wr(1'b1, 9, 32'h99);
    bus.i_clear = 1'b1;
    set_rd(2'b10, 0, 9);
    bus.i_dbg_addr = 5'd9;
    push("clrwr_d1", S_D1, 32'h55);
    push("clrwr_v1", S_V1, 32'd1);
    push("clrwr_dbg", S_DBG, 32'h55);
    push("clrwr_busy", S_BUSY, 32'd1);
    step();
    bus.i_clear = 1'b0;
    set_wr(1'b0, 0, 32'h0);
    set_rd(2'b00, 0, 0);

    // Clear during a sweep restarts the counter.
    for (int i = 0; i < 5; i++) step();
    bus.i_clear = 1'b1;
    step();
    bus.i_clear = 1'b0;
    wait_idle(n);
    check("restart_sweep_len", n, 32);
    set_rd(2'b11, 5, 9);
    push("restart_d0", S_D0, 32'd0);
    push("restart_d1", S_D1, 32'd0);
    step();

    // Fill r1..r31 with their index, then clear with a write attempted during busy.
    set_rd(2'b00, 0, 0);
    for (int i = 1; i < 32; i++) begin
      set_wr(1'b1, i, 32'(i));
      step();
    end
    set_wr(1'b0, 0, 32'h0);
    set_rd(2'b11, 31, 1);
    bus.i_dbg_addr = 5'd17;
    push("fill_d0", S_D0, 32'd31);
    push("fill_d1", S_D1, 32'd1);
    push("fill_dbg", S_DBG, 32'd17);
    step();
    set_rd(2'b00, 0, 0);
    bus.i_clear = 1'b1;
    push("fill_clr_busy", S_BUSY, 32'd1);
    step();
    bus.i_clear = 1'b0;
    set_wr(1'b1, 3, 32'hAAAA);
    set_rd(2'b11, 3, 3);
    push("busy_v0", S_V0, 32'd0);
    push("busy_d0", S_D0, 32'd0);
    push("busy_dbg", S_DBG, 32'd0);
    step();
    set_wr(1'b0, 0, 32'h0);
    set_rd(2'b00, 0, 0);
    wait_idle(n);
    check("fill_sweep_len", n, 31);
    for (int i = 1; i < 32; i++) begin
      set_rd(2'b11, i, 32 - i);
      bus.i_dbg_addr = AW'(i);
      push($sformatf("swept_d0_r%0d", i), S_D0, 32'd0);
      push($sformatf("swept_d1_r%0d", 32 - i), S_D1, 32'd0);
      push($sformatf("swept_dbg_r%0d", i), S_DBG, 32'd0);
      push("swept_v0", S_V0, 32'd1);
      step();
    end

    // Reset asserted while outputs hold nonzero data clears them at once.
    set_rd(2'b00, 0, 0);
    set_wr(1'b1, 4, 32'h44);
    step();
    set_wr(1'b0, 0, 32'h0);
    set_rd(2'b01, 4, 0);
    bus.i_dbg_addr = 5'd4;
    push("r4_d0", S_D0, 32'h44);
    push("r4_dbg", S_DBG, 32'h44);
    step();
    i_reset = 1'b1;
    #1;
    push("async_rst_d0", S_D0, 32'd0);
    push("async_rst_v0", S_V0, 32'd0);
    push("async_rst_dbg", S_DBG, 32'd0);
    push("async_rst_busy", S_BUSY, 32'd1);
    drain();
    set_rd(2'b00, 0, 0);
    step();
    i_reset = 1'b0;
    wait_idle(n);
    check("rst2_sweep_len", n, 32);

    // Reset at sweep cycle 10 restarts the sweep from index 0.
    bus.i_clear = 1'b1;
    step();
    bus.i_clear = 1'b0;
    for (int i = 0; i < 10; i++) step();
    i_reset = 1'b1;
    #1;
    push("midrst_busy", S_BUSY, 32'd1);
    drain();
    step();
    step();
    i_reset = 1'b0;
    push("midrst_rel_busy", S_BUSY, 32'd1);
    drain();
    wait_idle(n);
    check("midrst_sweep_len", n, 32);
    set_rd(2'b01, 4, 0);
    push("final_r4_d0", S_D0, 32'd0);
    push("final_r4_v0", S_V0, 32'd1);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion, expected finish before 200000");
    $fatal(1);
  end

endmodule
